div_arbiter: RTL and testbench

- Sequences and shares the single restoring divider between two requesters, A and B.
- A is wired to the divider's Dividend1/Divisor1 operand set and B to Dividend2/Divisor2; this block drives the divider's enable and select lines.
- Runs a round-robin grant, walks the divider through start, run and done, captures the quotient into a per-requester result register and acknowledges the winner.
- A watchdog aborts a divide that never completes.

---
 rtl/div_arbiter_if.sv | 30 +++
 rtl/div_arbiter.sv | 112 +++++++++++
 tb/tb_div_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// Bundle of requester-side and divider-side signals for the divider arbiter.
// master is the arbiter's view; slave is the view of the requesters and divider.
interface div_arbiter_if #(
  parameter int WIDTH = 12
);
  logic             req_a;
  logic             req_b;
  logic             ack_a;
  logic             ack_b;
  logic [WIDTH-1:0] res_a;
  logic [WIDTH-1:0] res_b;
  logic             err;
  logic             grant_a;
  logic             grant_b;
  logic             div_en;
  logic             div_sel;
  logic             div_busy;
  logic             div_ready;
  logic [WIDTH-1:0] div_res;

  modport master (
    input  req_a, req_b, div_busy, div_ready, div_res,
    output ack_a, ack_b, res_a, res_b, err, grant_a, grant_b, div_en, div_sel
  );

  modport slave (
    output req_a, req_b, div_busy, div_ready, div_res,
    input  ack_a, ack_b, res_a, res_b, err, grant_a, grant_b, div_en, div_sel
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one restoring divider between requesters A and B,
// with a watchdog that aborts a divide that never completes.
module div_arbiter #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  div_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, START, RUN, DONE, ABORT} state_t;

  state_t           state_reg, state_next;
  logic             owner_reg;   // 1 = A owns the divider
  logic             last_reg;    // 1 = A was served last
  logic [TMR_W-1:0] timer_reg;
  logic             grant_a_reg, grant_b_reg;
  logic             ack_a_reg, ack_b_reg, err_reg;
  logic [WIDTH-1:0] res_a_reg, res_b_reg;

  logic eff_a, eff_b, pick_a, timeout;

  // A request still high in its own ack cycle is the one just served.
  assign eff_a   = bus.req_a & ~ack_a_reg;
  assign eff_b   = bus.req_b & ~ack_b_reg;
  assign pick_a  = eff_a & (~eff_b | ~last_reg);
  assign timeout = (timer_reg == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (eff_a | eff_b) state_next = START;
      START: begin
        if (timeout)           state_next = ABORT;
        else if (bus.div_busy) state_next = RUN;
      end
      RUN: begin
        if (bus.div_ready && !bus.div_busy) state_next = DONE;
        else if (timeout)                   state_next = ABORT;
      end
      DONE:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.div_en  = (state_reg == START) || (state_reg == RUN);
    bus.div_sel = owner_reg;
    bus.grant_a = grant_a_reg;
    bus.grant_b = grant_b_reg;
    bus.ack_a   = ack_a_reg;
    bus.ack_b   = ack_b_reg;
    bus.err     = err_reg;
    bus.res_a   = res_a_reg;
    bus.res_b   = res_b_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg   <= 1'b0;
      last_reg    <= 1'b0;
      timer_reg   <= '0;
      grant_a_reg <= 1'b0;
      grant_b_reg <= 1'b0;
      ack_a_reg   <= 1'b0;
      ack_b_reg   <= 1'b0;
      err_reg     <= 1'b0;
      res_a_reg   <= '0;
      res_b_reg   <= '0;
    end else begin
      ack_a_reg <= 1'b0;
      ack_b_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          timer_reg <= '0;
          if (eff_a | eff_b) begin
            owner_reg   <= pick_a;
            grant_a_reg <= pick_a;
            grant_b_reg <= ~pick_a;
          end
        end
        START, RUN: timer_reg <= timer_reg + 1'b1;
        DONE, ABORT: begin
          // A watchdog abort reports a zero quotient alongside err.
          if (owner_reg) begin
            ack_a_reg <= 1'b1;
            res_a_reg <= (state_reg == DONE) ? bus.div_res : '0;
          end else begin
            ack_b_reg <= 1'b1;
            res_b_reg <= (state_reg == DONE) ? bus.div_res : '0;
          end
          err_reg     <= (state_reg == ABORT);
          last_reg    <= owner_reg;
          grant_a_reg <= 1'b0;
          grant_b_reg <= 1'b0;
          timer_reg   <= '0;
        end
        default: timer_reg <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a cycle-level model of the shared divider.
module tb_div_arbiter;
  localparam int WIDTH   = 12;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic model_rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, kill_busy = 1'b0;
  logic [WIDTH-1:0] dividend1 = '0, divisor1 = '0, dividend2 = '0, divisor2 = '0;

  int passed = 0, total = 0, inv_viol = 0, en_total = 0;

  always #5 clk = ~clk;

  div_arbiter_if #(.WIDTH(WIDTH)) bus ();

  div_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TMR_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Divider model: one cycle to clear its post-completion wait, one to load,
  // then 48 busy cycles; Ready stays high until the next load.
  logic             m_busy, m_ready, m_wait, m_loaded;
  logic [5:0]       m_cnt;
  logic [WIDTH-1:0] m_q, m_res;

  function automatic logic [WIDTH-1:0] qdiv(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] v);
    return (v == 0) ? '0 : d / v;
  endfunction

  always @(posedge clk) begin
    if (!model_rst_n) begin
      m_busy <= 0; m_ready <= 0; m_wait <= 0; m_loaded <= 0; m_cnt <= 0; m_q <= 0; m_res <= 0;
    end else if (!bus.div_en) begin
      m_busy <= 0; m_loaded <= 0;
    end else if (m_wait) begin
      m_wait <= 0;
    end else if (!m_loaded) begin
      m_loaded <= 1; m_busy <= 1; m_ready <= 0; m_cnt <= 0;
      m_q <= bus.div_sel ? qdiv(dividend1, divisor1) : qdiv(dividend2, divisor2);
    end else if (m_busy) begin
      if (m_cnt == 6'd47) begin
        m_busy <= 0; m_ready <= 1; m_res <= m_q; m_wait <= 1;
      end else m_cnt <= m_cnt + 6'd1;
    end
  end

  assign bus.req_a     = req_a;
  assign bus.req_b     = req_b;
  assign bus.div_busy  = m_busy & ~kill_busy;
  assign bus.div_ready = m_ready;
  assign bus.div_res   = m_res;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.grant_a && bus.grant_b) inv_viol <= inv_viol + 1;
      if (bus.ack_a && bus.ack_b) inv_viol <= inv_viol + 1;
      if (bus.div_en && !bus.grant_a && !bus.grant_b) inv_viol <= inv_viol + 1;
      if (bus.div_en) en_total <= en_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_ack(output logic ga, output logic gb, output logic ge, output int cycles);
    cycles = 0;
    while (!(bus.ack_a || bus.ack_b) && cycles < 600) begin
      @(negedge clk);
      cycles++;
    end
    check("ack_seen", {31'd0, bus.ack_a | bus.ack_b}, 1);
    ga = bus.ack_a; gb = bus.ack_b; ge = bus.err;
    $display("txn: ack_a=%0b ack_b=%0b err=%0b res_a=%0d res_b=%0d cycles=%0d",
             ga, gb, ge, bus.res_a, bus.res_b, cycles);
  endtask

  logic ga, gb, ge;
  int   cyc, en_start;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack_a", bus.ack_a, 0);
    check("rst_ack_b", bus.ack_b, 0);
    check("rst_err", bus.err, 0);
    check("rst_grants", {bus.grant_a, bus.grant_b}, 0);
    check("rst_div_en", bus.div_en, 0);
    check("rst_div_sel", bus.div_sel, 0);
    check("rst_res_a", bus.res_a, 0);
    check("rst_res_b", bus.res_b, 0);
    model_rst_n = 1; rst_n = 1;
    repeat (2) @(negedge clk);

    // A only: 100/7
    dividend1 = 100; divisor1 = 7; req_a = 1;
    @(negedge clk);
    check("a_grant", bus.grant_a, 1);
    check("a_div_sel", bus.div_sel, 1);
    check("a_div_en", bus.div_en, 1);
    wait_ack(ga, gb, ge, cyc);
    check("a_ack", {ga, gb}, 2'b10);
    check("a_err", ge, 0);
    check("a_res", bus.res_a, 14);
    check("a_res_b_zero", bus.res_b, 0);
    check("a_latency_le_60", {31'd0, cyc <= 60}, 1);
    req_a = 0;
    @(negedge clk);
    check("a_ack_one_pulse", bus.ack_a, 0);
    check("a_no_regrant", bus.grant_a, 0);

    // Reset, then A and B together; A wins the first tie, then fairness A,B,A
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    dividend2 = 4095; divisor2 = 5;
    req_a = 1; req_b = 1;
    @(negedge clk);
    check("tie_grant_a", {bus.grant_a, bus.grant_b}, 2'b10);
    wait_ack(ga, gb, ge, cyc);
    check("tie_first_ack_a", {ga, gb}, 2'b10);
    check("tie_res_a", bus.res_a, 14);
    req_a = 0;
    @(negedge clk);
    check("fair_grant_b", {bus.grant_a, bus.grant_b}, 2'b01);
    check("fair_sel_b", bus.div_sel, 0);
    dividend1 = 144; divisor1 = 12; req_a = 1;
    wait_ack(ga, gb, ge, cyc);
    check("fair_ack_b", {ga, gb}, 2'b01);
    check("fair_res_b", bus.res_b, 819);
    check("fair_err_b", ge, 0);
    req_b = 0;
    @(negedge clk);
    check("fair_grant_a_again", {bus.grant_a, bus.grant_b}, 2'b10);
    wait_ack(ga, gb, ge, cyc);
    check("fair_ack_a_again", {ga, gb}, 2'b10);
    check("fair_res_a_again", bus.res_a, 12);
    req_a = 0;
    @(negedge clk);

    // Divide by zero on B
    dividend2 = 50; divisor2 = 0; req_b = 1;
    wait_ack(ga, gb, ge, cyc);
    check("dz_ack_b", {ga, gb}, 2'b01);
    check("dz_err", ge, 0);
    check("dz_res_b", bus.res_b, 0);
    check("dz_res_a_kept", bus.res_a, 12);
    req_b = 0;
    @(negedge clk);

    // Watchdog: Busy never rises
    kill_busy = 1; dividend1 = 100; divisor1 = 7;
    en_start = en_total;
    req_a = 1;
    wait_ack(ga, gb, ge, cyc);
    check("wd_ack_a", {ga, gb}, 2'b10);
    check("wd_err", ge, 1);
    check("wd_res_a", bus.res_a, 0);
    check("wd_div_en", bus.div_en, 0);
    check("wd_en_cycles", en_total - en_start, TIMEOUT);
    req_a = 0; kill_busy = 0;
    @(negedge clk);
    check("wd_err_one_pulse", bus.err, 0);
    dividend2 = 30; divisor2 = 4; req_b = 1;
    wait_ack(ga, gb, ge, cyc);
    check("wd_after_ack_b", {ga, gb}, 2'b01);
    check("wd_after_res_b", bus.res_b, 7);
    check("wd_after_err", ge, 0);
    req_b = 0;
    @(negedge clk);

    // Reset in the middle of RUN
    dividend1 = 100; divisor1 = 7; req_a = 1;
    cyc = 0;
    while (!bus.div_busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_busy_seen", bus.div_busy, 1);
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    check("mid_div_en", bus.div_en, 0);
    check("mid_grant_a", bus.grant_a, 0);
    check("mid_div_sel", bus.div_sel, 0);
    check("mid_ack_err", {bus.ack_a, bus.ack_b, bus.err}, 0);
    check("mid_res_a", bus.res_a, 0);
    check("mid_res_b", bus.res_b, 0);
    repeat (3) @(negedge clk);
    check("mid_no_ack_in_reset", {bus.ack_a, bus.ack_b}, 0);
    dividend1 = 81; divisor1 = 9;
    rst_n = 1;
    wait_ack(ga, gb, ge, cyc);
    check("post_rst_ack_a", {ga, gb}, 2'b10);
    check("post_rst_res_a", bus.res_a, 9);
    check("post_rst_err", ge, 0);
    req_a = 0;
    repeat (2) @(negedge clk);

    check("invariants", inv_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
